// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// Each grant carries at most BURST_LEN beats and is followed by one IDLE bubble.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [15:0]                   wr_count
);

  // Handshake: a beat is req_valid[g] && req_ready[g]; producers hold valid and
  // data stable until ready, and dropping valid early releases the grant.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic [GW-1:0]         winner;
  logic [GW-1:0]         cand;
  logic                  found;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_valid;
  logic                  beat;

  // Rotating search starting just above the previous owner.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((int'(last_grant_q) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_data  = '0;
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        owner_valid = req_valid[i];
      end
    end
  end

  // fifo_full reaches ready/wr_en combinationally, so it must come from a flop in fifo_top.
  always_comb begin
    busy = (state_q == ST_GRANT);
    beat = busy && owner_valid && !fifo_full;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy && !fifo_full && (grant_id_q == GW'(i));
    end
    fifo_wr_en = beat;
    fifo_din   = busy ? owner_data : '0;
    grant_id   = grant_id_q;
    wr_count   = wr_count_q;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    wr_count_d   = wr_count_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d      = ST_GRANT;
          grant_id_d   = winner;
          last_grant_d = winner;
          beat_cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          wr_count_d = wr_count_q + 16'd1;
        end
        // Full with valid held freezes everything: no timeout by design.
        if ((beat && beat_cnt_q == CW'(BURST_LEN - 1)) || !owner_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_count_q   <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: table-driven producers, in-order data scoreboard,
// cycle-pattern and grant-order checks, async reset mid-burst.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_din;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      wr_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    gid_q[$];
  logic [DW-1:0] mem [NR][16];
  int            len [NR];
  int            ptr [NR];
  int            cyc;
  logic [31:0]   wr_hist;

  logic [NR-1:0] s_ready;
  logic          s_wr_en;
  logic          s_busy;
  logic [1:0]    s_grant;
  logic [15:0]   s_wr_count;
  logic [2:0]    s_beat;

  int rr_exp [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
  int per_cnt [NR];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (ptr[i] < len[i]);
      req_data[i*DW +: DW] = '0;
      if (ptr[i] < len[i]) req_data[i*DW +: DW] = mem[i][ptr[i]];
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] base, input int n);
    for (int k = 0; k < n; k++) mem[i][k] = base + DW'(k);
    len[i] = n;
    ptr[i] = 0;
  endtask

  task automatic clear_logs();
    cyc = 0;
    wr_hist = '0;
    gid_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    exp_q.delete();
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    drive();
    clear_logs();
  endtask

  // One cycle: sample at negedge, score writes, advance producers after the edge.
  task automatic tick();
    logic [NR-1:0] hs;
    @(negedge clk);
    s_ready    = req_ready;
    s_wr_en    = fifo_wr_en;
    s_busy     = busy;
    s_grant    = grant_id;
    s_wr_count = wr_count;
    s_beat     = dut.beat_cnt_q;
    check("ready_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
    if (fifo_wr_en) begin
      gid_q.push_back(grant_id);
      if (exp_q.size() == 0) check("unexpected_write", {31'b0, fifo_wr_en}, 32'd0);
      else check("din", {24'b0, fifo_din}, {24'b0, exp_q.pop_front()});
    end
    if (cyc < 32) wr_hist[cyc] = fifo_wr_en;
    cyc++;
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) ptr[i]++;
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (ptr[i] < len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int budget);
    int n;
    tick();
    n = 1;
    while (n < budget && !(all_done() && exp_q.size() == 0 && !s_busy)) begin
      tick();
      n++;
    end
    check("run_timeout", {31'b0, (n < budget)}, 32'd1);
  endtask

  initial begin
    // reset with all producers valid
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) load(i, DW'(i * 16), 1);
    drive();
    exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'h20); exp_q.push_back(8'h30);
    repeat (3) begin
      tick();
      check("rst_ready", {28'b0, s_ready}, 32'd0);
      check("rst_wr_en", {31'b0, s_wr_en}, 32'd0);
      check("rst_busy", {31'b0, s_busy}, 32'd0);
      check("rst_grant", {30'b0, s_grant}, 32'd0);
      check("rst_wr_count", {16'b0, s_wr_count}, 32'd0);
    end
    release_reset();
    tick();
    check("first_idle", {31'b0, s_busy}, 32'd0);
    tick();
    check("first_grant", {30'b0, s_grant}, 32'd0);
    check("first_busy", {31'b0, s_busy}, 32'd1);
    run(100);
    check("rot_count", gid_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) check("rot_order", {30'b0, gid_q[k]}, k);
    check("rot_wr_count", {16'b0, wr_count}, 32'd4);

    // single producer, 10 words, bursts of 4,4,2
    do_reset();
    load(2, 8'h10, 10);
    for (int k = 0; k < 10; k++) exp_q.push_back(8'h10 + DW'(k));
    release_reset();
    run(100);
    check("single_pattern", wr_hist, 32'h0000_1BDE);
    check("single_count", gid_q.size(), 32'd10);
    foreach (gid_q[k]) check("single_gid", {30'b0, gid_q[k]}, 32'd2);
    check("single_grant_hold", {30'b0, grant_id}, 32'd2);
    check("single_wr_count", {16'b0, wr_count}, 32'd10);

    // round-robin with 6 words per producer
    do_reset();
    for (int i = 0; i < NR; i++) load(i, DW'(i * 16), 6);
    for (int i = 0; i < NR; i++) for (int k = 0; k < 4; k++) exp_q.push_back(DW'(i * 16 + k));
    for (int i = 0; i < NR; i++) for (int k = 4; k < 6; k++) exp_q.push_back(DW'(i * 16 + k));
    release_reset();
    run(300);
    check("rr_count", gid_q.size(), 32'd24);
    for (int k = 0; k < 24; k++) check("rr_order", {30'b0, gid_q[k]}, rr_exp[k]);
    for (int i = 0; i < NR; i++) per_cnt[i] = 0;
    foreach (gid_q[k]) per_cnt[gid_q[k]]++;
    for (int i = 0; i < NR; i++) check("rr_per_producer", per_cnt[i], 32'd6);
    check("rr_wr_count", {16'b0, wr_count}, 32'd24);

    // full back-pressure after beat 2 of producer 1
    do_reset();
    load(1, 8'h40, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h40 + DW'(k));
    release_reset();
    repeat (3) tick();
    fifo_full = 1'b1;
    repeat (3) begin
      tick();
      check("full_ready", {28'b0, s_ready}, 32'd0);
      check("full_wr_en", {31'b0, s_wr_en}, 32'd0);
      check("full_grant", {30'b0, s_grant}, 32'd1);
      check("full_busy", {31'b0, s_busy}, 32'd1);
      check("full_beat_cnt", {29'b0, s_beat}, 32'd2);
    end
    fifo_full = 1'b0;
    run(50);
    check("full_pattern", wr_hist, 32'h0000_00C6);
    check("full_wr_count", {16'b0, wr_count}, 32'd4);

    // early release by producer 0 while producer 3 waits
    do_reset();
    load(0, 8'h50, 2);
    load(3, 8'h60, 2);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    exp_q.push_back(8'h60); exp_q.push_back(8'h61);
    release_reset();
    repeat (4) tick();
    check("rel_wr_count", {16'b0, s_wr_count}, 32'd2);
    check("rel_release_cycle_busy", {31'b0, s_busy}, 32'd1);
    check("rel_release_cycle_wr_en", {31'b0, s_wr_en}, 32'd0);
    tick();
    check("rel_bubble", {31'b0, s_busy}, 32'd0);
    tick();
    check("rel_next_grant", {30'b0, s_grant}, 32'd3);
    check("rel_next_wr_en", {31'b0, s_wr_en}, 32'd1);
    run(50);
    check("rel_pattern", wr_hist, 32'h0000_0066);
    check("rel_final_wr_count", {16'b0, wr_count}, 32'd4);

    // async reset during beat 3 of producer 2
    do_reset();
    load(2, 8'h20, 4);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    release_reset();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("arst_ready", {28'b0, req_ready}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_din", {24'b0, fifo_din}, 32'd0);
    check("arst_grant", {30'b0, grant_id}, 32'd0);
    check("arst_wr_count", {16'b0, wr_count}, 32'd0);
    check("arst_beat_cnt", {29'b0, dut.beat_cnt_q}, 32'd0);
    repeat (2) begin
      tick();
      check("arst_hold_wr_en", {31'b0, s_wr_en}, 32'd0);
    end
    load(0, 8'h05, 1);
    exp_q.delete();
    exp_q.push_back(8'h05); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    release_reset();
    run(50);
    check("arst_after_count", gid_q.size(), 32'd3);
    check("arst_restart_p0", {30'b0, gid_q[0]}, 32'd0);
    check("arst_then_p2_a", {30'b0, gid_q[1]}, 32'd2);
    check("arst_then_p2_b", {30'b0, gid_q[2]}, 32'd2);
    check("arst_final_wr_count", {16'b0, wr_count}, 32'd3);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
